// File: rtl/score_digits_pkg.sv
// Shared definitions for the score_digits block.
//
// Contents:
//   bcd_t               one 4-bit BCD digit (legal values 0..9)
//   score_t             four BCD digits; [0] is units and [3] is thousands
//   seg_t               segment pattern indexed [0:6], bit [0] first
//   SEG_0..SEG_9        digit-to-segment patterns
//   SEG_BLANK           pattern for any non-BCD input
//   state_t             game state encoding: ST_IDLE, ST_RUN, ST_OVER
//   SCORE_MAX           saturation value of the score (9999)
package score_digits_pkg;

  typedef logic [3:0]      bcd_t;
  typedef logic [3:0][3:0] score_t;
  typedef logic [0:6]      seg_t;

  localparam seg_t SEG_0     = 7'b1111110;
  localparam seg_t SEG_1     = 7'b0110000;
  localparam seg_t SEG_2     = 7'b1101101;
  localparam seg_t SEG_3     = 7'b1111001;
  localparam seg_t SEG_4     = 7'b0110011;
  localparam seg_t SEG_5     = 7'b1011011;
  localparam seg_t SEG_6     = 7'b1011111;
  localparam seg_t SEG_7     = 7'b1110000;
  localparam seg_t SEG_8     = 7'b1111111;
  localparam seg_t SEG_9     = 7'b1111011;
  localparam seg_t SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  localparam score_t SCORE_MAX = 16'h9999;

endpackage

// File: rtl/score_digits_if.sv
// Signal bundle between the game logic and the score_digits block.
//
// Signals:
//   frame_tick  one-cycle pulse per VGA frame
//   restart     one-cycle pulse: clear score and start or restart play
//   game_over   one-cycle pulse: collision detected, stop play
//   show_hi     level: display the high score instead of the score
//   seg_d0..3   [0:6] segment patterns, units..thousands
//   playing     high while the game runs
//   new_hi      one-cycle pulse when the high score is replaced
//
// Modports:
//   master  drives the control inputs and observes the display outputs
//   slave   the score_digits block itself
interface score_digits_if;
  import score_digits_pkg::*;

  logic frame_tick;
  logic restart;
  logic game_over;
  logic show_hi;
  seg_t seg_d0;
  seg_t seg_d1;
  seg_t seg_d2;
  seg_t seg_d3;
  logic playing;
  logic new_hi;

  modport master (
    output frame_tick, restart, game_over, show_hi,
    input  seg_d0, seg_d1, seg_d2, seg_d3, playing, new_hi
  );

  modport slave (
    input  frame_tick, restart, game_over, show_hi,
    output seg_d0, seg_d1, seg_d2, seg_d3, playing, new_hi
  );

endinterface

// File: rtl/score_digits_seg_decoder.sv
// Purely combinational BCD digit to [0:6] segment-pattern lookup.
//
// Ports:
//   digit_i  input  4  BCD digit
//   seg_o    output 7  segment pattern, bit [0] first; blank for non-BCD
module seg_decoder
  import score_digits_pkg::*;
(
  input  bcd_t digit_i,
  output seg_t seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (digit_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/score_digits.sv
// Running 4-digit BCD score for the goose-run VGA game. The score advances
// once every FRAMES_PER_POINT frames while the game runs, saturates at 9999,
// freezes on game over, and is shown as four registered segment patterns.
//
// Ports:
//   clk    input   system/pixel clock, the only clock
//   reset  input   synchronous, active-high
//   bus    slave   score_digits_if (frame_tick, restart, game_over, show_hi
//                  in; seg_d0..seg_d3, playing, new_hi out)
//
// Parameters:
//   FRAMES_PER_POINT  frame ticks per score point, 1..255
//   PRESCALE_W        prescaler width, must hold FRAMES_PER_POINT-1
//
// Build option: define SCORE_DIGITS_HISCORE_EN to add the high-score register,
// the show_hi display select and the new_hi pulse. Without it show_hi is
// ignored and new_hi is held low.
module score_digits
  import score_digits_pkg::*;
#(
  parameter int unsigned FRAMES_PER_POINT = 6,
  parameter int unsigned PRESCALE_W       = 8
) (
  input  logic           clk,
  input  logic           reset,
  score_digits_if.slave  bus
);

  localparam logic [PRESCALE_W-1:0] PRESCALE_LAST = PRESCALE_W'(FRAMES_PER_POINT - 1);
  localparam logic [PRESCALE_W-1:0] PRESCALE_ONE  = PRESCALE_W'(1);

  state_t                 state_q, state_d;
  logic [PRESCALE_W-1:0]  prescale_q, prescale_d;
  score_t                 score_q, score_d;
  score_t                 score_inc;
  logic                   playing_q, playing_d;
  logic [3:0][0:6]        seg_q;
  logic [3:0][0:6]        seg_dec;
  score_t                 disp;
  logic                   carry;

  // Score plus one; the carry ripples through all four digits in one cycle.
  always_comb begin
    score_inc = score_q;
    carry     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (score_q[i] == 4'd9) begin
          score_inc[i] = 4'd0;
        end else begin
          score_inc[i] = score_q[i] + 4'd1;
          carry        = 1'b0;
        end
      end
    end
  end

  // Next state: restart beats game_over, and game_over suppresses any
  // scoring tick in the same cycle.
  always_comb begin
    state_d    = state_q;
    prescale_d = prescale_q;
    score_d    = score_q;
    if (bus.restart) begin
      state_d    = ST_RUN;
      prescale_d = '0;
      score_d    = '0;
    end else if (state_q == ST_RUN) begin
      if (bus.game_over) begin
        state_d = ST_OVER;
      end else if (bus.frame_tick) begin
        if (prescale_q == PRESCALE_LAST) begin
          prescale_d = '0;
          if (score_q != SCORE_MAX) begin
            score_d = score_inc;
          end
        end else begin
          prescale_d = prescale_q + PRESCALE_ONE;
        end
      end
    end
    playing_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      prescale_q <= '0;
      score_q    <= '0;
      playing_q  <= 1'b0;
      seg_q      <= {4{SEG_0}};
    end else begin
      state_q    <= state_d;
      prescale_q <= prescale_d;
      score_q    <= score_d;
      playing_q  <= playing_d;
      seg_q      <= seg_dec;
    end
  end

`ifdef SCORE_DIGITS_HISCORE_EN
  score_t hi_q, hi_d;
  logic   new_hi_q, new_hi_d;

  // Packed BCD digits compare correctly as a plain 16-bit magnitude.
  always_comb begin
    hi_d     = hi_q;
    new_hi_d = 1'b0;
    if (!bus.restart && (state_q == ST_RUN) && bus.game_over && (score_q > hi_q)) begin
      hi_d     = score_q;
      new_hi_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q     <= '0;
      new_hi_q <= 1'b0;
    end else begin
      hi_q     <= hi_d;
      new_hi_q <= new_hi_d;
    end
  end

  assign disp       = bus.show_hi ? hi_q : score_q;
  assign bus.new_hi = new_hi_q;
`else
  logic unused_show_hi;

  assign unused_show_hi = bus.show_hi;
  assign disp           = score_q;
  assign bus.new_hi     = 1'b0;
`endif

  for (genvar g = 0; g < 4; g++) begin : g_dec
    seg_decoder u_dec (
      .digit_i (disp[g]),
      .seg_o   (seg_dec[g])
    );
  end

  assign bus.seg_d0  = seg_q[0];
  assign bus.seg_d1  = seg_q[1];
  assign bus.seg_d2  = seg_q[2];
  assign bus.seg_d3  = seg_q[3];
  assign bus.playing = playing_q;

endmodule
